instr_cache: RTL and testbench
==============================

INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 8 blocks x 16 bytes, direct-mapped, for a 1024-byte instruction memory.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port PC, input, 32, CPU byte address; only bits [9:2] are used.
REQ-005 SHALL have port INSTRUCTION, output, 32, the fetched instruction word.
REQ-006 SHALL have port BUSYWAIT, output, 1, CPU stall request.
REQ-007 SHALL have port MEM_READ, output, 1, memory block read request.
REQ-008 SHALL have port MEM_ADDRESS, output, 6, memory block address {tag, index}.
REQ-009 SHALL have port MEM_READDATA, input, 128, memory block; word 0 is in bits [31:0].
REQ-010 SHALL have port MEM_BUSYWAIT, input, 1, memory busy; data is valid in the cycle it falls.
REQ-011 SHALL have ports HIT_COUNT and MISS_COUNT, each output, 16, present only under ICACHE_STATS_EN.

Function
REQ-012 SHALL decode the address as tag = PC[9:7], index = PC[6:4], word = PC[3:2], and ignore PC[1:0].
REQ-013 SHALL declare a hit when valid[index] is set and tag[index] equals the PC tag; the hit is combinational.
REQ-014 SHALL, on a hit in IDLE, drive INSTRUCTION from the selected word in the same cycle, with BUSYWAIT at 0.
REQ-015 SHALL, on a miss in IDLE, assert BUSYWAIT combinationally and enter MEM_READ at the next edge.
REQ-016 SHALL implement FSM states IDLE, MEM_READ and UPDATE; no other states.
REQ-017 SHALL, in MEM_READ, hold MEM_READ=1, MEM_ADDRESS={PC tag, index} and BUSYWAIT=1.
REQ-018 SHALL leave MEM_READ for UPDATE at the first edge where MEM_BUSYWAIT=0, with no fixed latency assumed.
REQ-019 SHALL, in UPDATE, write data[index]=MEM_READDATA, tag[index] and valid[index]=1 at the edge, with MEM_READ=0 and BUSYWAIT=1.
REQ-020 SHALL move from UPDATE to IDLE unconditionally; the re-lookup then hits and BUSYWAIT falls in that cycle.
REQ-021 SHALL give a miss penalty of exactly (memory latency cycles + 2) stalled cycles.
REQ-022 SHALL treat PC as stable while BUSYWAIT=1; a PC change in MEM_READ or UPDATE is a protocol violation with undefined data.
REQ-023 SHALL always drive MEM_READ low in IDLE and UPDATE.
REQ-024 SHALL drive INSTRUCTION to 32'h0 while BUSYWAIT=1.

Reset
REQ-025 SHALL, on RESET=0, immediately clear all valid bits, force IDLE, and drive MEM_READ=0 and BUSYWAIT=0.
REQ-026 SHALL abandon any memory transaction under reset mid-operation; a late MEM_BUSYWAIT fall SHALL NOT fill a block.
REQ-027 SHALL leave data and tag arrays uninitialised under reset; valid=0 masks their contents.
REQ-028 SHALL start the first fetch after reset release as a miss.

Configuration
REQ-029 SHALL, with ICACHE_STATS_EN defined, count one hit per IDLE hit cycle and one miss per IDLE-to-MEM_READ transition.
REQ-030 SHALL make both counters saturate at 16'hFFFF and reset to 0 under RESET.
REQ-031 SHALL, without ICACHE_STATS_EN, omit the counter ports and logic, with no other behavioural change.

Structure
REQ-032 SHALL place in package icache_pkg the state enum (IDLE, MEM_READ, UPDATE), the tag, index and word widths, and the block size constant.
REQ-033 SHALL isolate the FSM and handshake in sub-module icache_ctrl; storage and hit logic stay in instr_cache.

Verification
REQ-034 SHALL check reset then PC=0, memory latency 5 -> BUSYWAIT high 7 cycles, MEM_ADDRESS=6'd0, then INSTRUCTION=mem word 0.
REQ-035 SHALL check PC=4, 8, 12 after the fill -> hits, BUSYWAIT stays 0, correct words returned in the same cycle.
REQ-036 SHALL check PC=0 then PC=128 (same index, tag 1) -> conflict miss, MEM_ADDRESS=6'd8; PC=0 again -> miss.
REQ-037 SHALL check PC=1020 -> MEM_ADDRESS=6'd63, word 3 of the block returned.
REQ-038 SHALL check RESET pulsed low during MEM_READ -> MEM_READ drops at once; a later MEM_BUSYWAIT fall leaves valid[0]=0.
REQ-039 SHALL check, under ICACHE_STATS_EN, sequence 0, 4, 128, 4 -> MISS_COUNT=3, HIT_COUNT=1.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Optional statistics counters are enabled with ICACHE_STATS_EN.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_e;

  localparam int TAG_W       = 3;
  localparam int INDEX_W     = 3;
  localparam int WORD_W      = 2;
  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_BITS  = BLOCK_BYTES * 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      return val;
    end else begin
      return val + 16'd1;
    end
  endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Miss-handling FSM for the instruction cache: IDLE lookup, MEM_READ
// handshake with the block memory, UPDATE fill cycle.
module icache_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic hit_i,
  input  logic mem_busywait_i,
  output logic busywait_o,
  output logic mem_read_o,
  output logic fill_o,
  output logic idle_o,
  output logic miss_start_o
);
  import icache_pkg::*;

  state_e state_q, state_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; memory latency is whatever MEM_BUSYWAIT says it is
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = hit_i ? IDLE : MEM_READ;
      MEM_READ: state_d = mem_busywait_i ? MEM_READ : UPDATE;
      UPDATE:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic; reset forces the stall low even while the lookup misses
  always_comb begin
    busywait_o   = 1'b0;
    mem_read_o   = 1'b0;
    fill_o       = 1'b0;
    idle_o       = 1'b0;
    miss_start_o = 1'b0;
    case (state_q)
      IDLE: begin
        idle_o       = 1'b1;
        busywait_o   = ~hit_i;
        miss_start_o = ~hit_i;
      end
      MEM_READ: begin
        busywait_o = 1'b1;
        mem_read_o = 1'b1;
      end
      UPDATE: begin
        busywait_o = 1'b1;
        fill_o     = 1'b1;
      end
      default: begin
        busywait_o = 1'b0;
      end
    endcase
    if (!rst_n) begin
      busywait_o   = 1'b0;
      miss_start_o = 1'b0;
    end else begin
      idle_o = idle_o;
    end
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped 8 x 16-byte instruction cache: storage, tag compare, word select.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module instr_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  HIT_COUNT,
  output logic [15:0]  MISS_COUNT
`endif
);
  import icache_pkg::*;

  logic [TAG_W-1:0]      pc_tag_s;
  logic [INDEX_W-1:0]    pc_index_s;
  logic [WORD_W-1:0]     pc_word_s;
  logic                  hit_s;
  logic                  fill_s;
  logic                  idle_s;
  logic                  miss_start_s;
  logic                  unused_pc_s;

  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_d  [NUM_BLOCKS];
  logic [BLOCK_BITS-1:0] data_q [NUM_BLOCKS];
  logic [BLOCK_BITS-1:0] data_d [NUM_BLOCKS];

  assign pc_tag_s    = PC[9:7];
  assign pc_index_s  = PC[6:4];
  assign pc_word_s   = PC[3:2];
  assign unused_pc_s = ^{PC[31:10], PC[1:0]};

  assign hit_s       = valid_q[pc_index_s] && (tag_q[pc_index_s] == pc_tag_s);
  assign MEM_ADDRESS = {pc_tag_s, pc_index_s};
  assign INSTRUCTION = (idle_s && hit_s) ? data_q[pc_index_s][pc_word_s*32 +: 32] : 32'h0;

  icache_ctrl u_ctrl (
    .clk            (CLK),
    .rst_n          (RESET),
    .hit_i          (hit_s),
    .mem_busywait_i (MEM_BUSYWAIT),
    .busywait_o     (BUSYWAIT),
    .mem_read_o     (MEM_READ),
    .fill_o         (fill_s),
    .idle_o         (idle_s),
    .miss_start_o   (miss_start_s)
  );

  // Block fill in the UPDATE cycle
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_s) begin
      valid_d[pc_index_s] = 1'b1;
      tag_d[pc_index_s]   = pc_tag_s;
      data_d[pc_index_s]  = MEM_READDATA;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only storage cleared by reset
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= {NUM_BLOCKS{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays, masked by valid_q
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef ICACHE_STATS_EN
  logic        post_fill_q, post_fill_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // The re-lookup right after a fill completes that miss; it is not a new hit
  always_comb begin
    post_fill_d = fill_s;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (idle_s && hit_s && !post_fill_q) begin
      hit_cnt_d = sat_inc16(hit_cnt_q);
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (miss_start_s) begin
      miss_cnt_d = sat_inc16(miss_cnt_q);
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      post_fill_q <= 1'b0;
      hit_cnt_q   <= 16'd0;
      miss_cnt_q  <= 16'd0;
    end else begin
      post_fill_q <= post_fill_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Directed self-checking bench for instr_cache with a latency-5 block memory model.
// Define ICACHE_STATS_EN to also check the hit/miss counters.
module tb_instr_cache;

  localparam int LAT = 5;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  int   rd_cnt   = 0;
  logic mem_hold = 1'b0;

  instr_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'hC0, a, 8'h5A, ~a};
  endfunction

  function automatic logic [127:0] mem_block(input logic [5:0] m);
    logic [7:0] base;
    base = {m, 2'b00};
    return {mem_word(base + 8'd3), mem_word(base + 8'd2), mem_word(base + 8'd1), mem_word(base)};
  endfunction

  // Memory responder: busy for LAT-1 cycles of MEM_READ, data valid on the falling cycle
  always @(posedge CLK) begin
    if (MEM_READ) rd_cnt <= rd_cnt + 1;
    else          rd_cnt <= 0;
  end
  assign MEM_BUSYWAIT = mem_hold | (MEM_READ && (rd_cnt < LAT - 1));
  assign MEM_READDATA = mem_block(MEM_ADDRESS);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input int exp_stall,
                       input logic [5:0] exp_addr);
    int         stalls;
    logic [5:0] seen_addr;
    @(negedge CLK);
    PC = pc;
    #1;
    stalls    = 0;
    seen_addr = 6'h3F ^ exp_addr;
    while (BUSYWAIT === 1'b1 && stalls < 40) begin
      if (stalls == 0) chk({tag, "_instr_stall"}, INSTRUCTION, 32'h0);
      if (MEM_READ === 1'b1) seen_addr = MEM_ADDRESS;
      stalls++;
      @(negedge CLK);
      #1;
    end
    chk({tag, "_stalls"}, stalls, exp_stall);
    if (exp_stall > 0) chk({tag, "_mem_addr"}, {26'd0, seen_addr}, {26'd0, exp_addr});
    chk({tag, "_instr"}, INSTRUCTION, mem_word(pc[9:2]));
  endtask

  initial begin
    int waited;
    RESET = 1'b0;
    PC    = 32'd0;
    #2;
    chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_instr", INSTRUCTION, 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b1;

    fetch("cold_pc0", 32'd0, LAT + 2, 6'd0);
    fetch("hit_pc4", 32'd4, 0, 6'd0);
    fetch("hit_pc8", 32'd8, 0, 6'd0);
    fetch("hit_pc12", 32'd12, 0, 6'd0);
    fetch("hit_pc0", 32'd0, 0, 6'd0);
    fetch("conf_pc128", 32'd128, LAT + 2, 6'd8);
    fetch("conf_pc0", 32'd0, LAT + 2, 6'd0);
    fetch("pc1020", 32'd1020, LAT + 2, 6'd63);
    fetch("pc1022_ignore_lsb", 32'd1022, 0, 6'd63);

    // Reset abandons an in-flight read; the late fall must not fill block 0
    mem_hold = 1'b1;
    @(negedge CLK);
    PC = 32'd128;
    waited = 0;
    #1;
    while (MEM_READ !== 1'b1 && waited < 10) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    chk("abort_mem_read_seen", {31'd0, MEM_READ}, 32'd1);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("abort_mem_read_drop", {31'd0, MEM_READ}, 32'd0);
    chk("abort_busywait_drop", {31'd0, BUSYWAIT}, 32'd0);
    @(negedge CLK);
    mem_hold = 1'b0;
    @(negedge CLK);
    PC = 32'd0;
    #1;
    chk("abort_in_reset_mem_read", {31'd0, MEM_READ}, 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    fetch("post_rst_pc0", 32'd0, LAT + 2, 6'd0);
    fetch("stat_pc4", 32'd4, 0, 6'd0);
    fetch("stat_pc128", 32'd128, LAT + 2, 6'd8);
    fetch("stat_pc4_miss", 32'd4, LAT + 2, 6'd0);
`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    chk("stat_miss_count", {16'd0, MISS_COUNT}, 32'd3);
    chk("stat_hit_count", {16'd0, HIT_COUNT}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
